// File: rtl/trng_word_arbiter.sv
// Buffers one 512-bit TRNG result as 16 x 32-bit words and hands each word out exactly once
// to round-robin arbitrated requesters, refilling automatically when the buffer runs dry.
module trng_word_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned GEN_TIMEOUT = 1024
) (
  input  logic            SCLK,
  input  logic            RST,
  input  logic            EN,
  output logic            GEN_START,
  input  logic            GEN_VALID,
  input  logic [511:0]    RANDOM_NUMBER,
  input  logic [NREQ-1:0] REQ,
  input  logic [NREQ-1:0] RD_READY,
  output logic [NREQ-1:0] GRANT,
  output logic            RD_VALID,
  output logic [31:0]     RD_DATA,
  output logic [4:0]      WORDS_LEFT,
  output logic            TIMEOUT_ERR
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(GEN_TIMEOUT + 1);
  // cnt_q counts completed WAIT_GEN cycles, so expiring here lands TIMEOUT_ERR exactly
  // GEN_TIMEOUT cycles after the GEN_START cycle.
  localparam logic [CW-1:0] CntLast = CW'(GEN_TIMEOUT - 2);

  typedef enum logic [1:0] {StIdle, StStart, StWaitGen, StServe} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     buf_q [16];
  logic [31:0]     buf_d [16];
  logic [3:0]      ptr_q, ptr_d;
  logic [4:0]      wl_q, wl_d;
  logic [IW-1:0]   last_q, last_d;
  logic            gvalid_q, gvalid_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic            terr_q, terr_d;

  logic [15:0][31:0] rn_words;
  logic              pick_found;
  logic [IW-1:0]     pick_idx;
  logic [IW-1:0]     cand;

  assign rn_words = RANDOM_NUMBER;

  // Round-robin search starting just after the last consumer served.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = IW'((32'(last_q) + i) % NREQ);
      if (!pick_found && REQ[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    ptr_d    = ptr_q;
    wl_d     = wl_q;
    last_d   = last_q;
    gvalid_d = gvalid_q;
    gidx_d   = gidx_q;
    terr_d   = terr_q;
    case (state_q)
      StIdle: begin
        if (EN && wl_q == 5'd0) begin
          state_d = StStart;
        end else if (wl_q != 5'd0) begin
          state_d = StServe;
        end
      end
      StStart: begin
        cnt_d   = '0;
        state_d = StWaitGen;
      end
      StWaitGen: begin
        cnt_d = cnt_q + CW'(1);
        if (GEN_VALID) begin
          for (int k = 0; k < 16; k++) begin
            buf_d[k[3:0]] = rn_words[4'(15 - k)];
          end
          wl_d    = 5'd16;
          ptr_d   = 4'd0;
          state_d = StServe;
        end else if (cnt_q == CntLast) begin
          terr_d  = 1'b1;
          state_d = StIdle;
        end
      end
      StServe: begin
        if (gvalid_q) begin
          if (RD_READY[gidx_q]) begin
            buf_d[ptr_q] = 32'h0;
            ptr_d        = ptr_q + 4'd1;
            wl_d         = wl_q - 5'd1;
            last_d       = gidx_q;
            gvalid_d     = 1'b0;
            if (wl_q == 5'd1) begin
              state_d = StIdle;
            end
          end else if (!REQ[gidx_q]) begin
            gvalid_d = 1'b0;
          end
        end else if (EN && wl_q != 5'd0 && pick_found) begin
          gvalid_d = 1'b1;
          gidx_d   = pick_idx;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge SCLK) begin
    if (!RST) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      for (int k = 0; k < 16; k++) begin
        buf_q[k[3:0]] <= 32'h0;
      end
      ptr_q    <= '0;
      wl_q     <= '0;
      last_q   <= IW'(NREQ - 1);
      gvalid_q <= 1'b0;
      gidx_q   <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      buf_q    <= buf_d;
      ptr_q    <= ptr_d;
      wl_q     <= wl_d;
      last_q   <= last_d;
      gvalid_q <= gvalid_d;
      gidx_q   <= gidx_d;
      terr_q   <= terr_d;
    end
  end

  assign GEN_START   = (state_q == StStart);
  assign GRANT       = {{(NREQ-1){1'b0}}, gvalid_q} << gidx_q;
  assign RD_VALID    = gvalid_q;
  assign RD_DATA     = gvalid_q ? buf_q[ptr_q] : 32'h0;
  assign WORDS_LEFT  = wl_q;
  assign TIMEOUT_ERR = terr_q;

endmodule

// File: tb/tb_trng_word_arbiter.sv
// Bench for trng_word_arbiter: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations for ordering, fairness, timeout and reset.
module tb_trng_word_arbiter;
  localparam int NREQ = 4;
  localparam int TO   = 12;

  logic            sclk = 1'b0;
  logic            rst, en, gen_valid;
  logic [511:0]    rn;
  logic [NREQ-1:0] req, rd_ready, grant;
  logic            gen_start, rd_valid, timeout_err;
  logic [31:0]     rd_data;
  logic [4:0]      words_left;

  trng_word_arbiter #(.NREQ(NREQ), .GEN_TIMEOUT(TO)) dut (
    .SCLK(sclk), .RST(rst), .EN(en), .GEN_START(gen_start), .GEN_VALID(gen_valid),
    .RANDOM_NUMBER(rn), .REQ(req), .RD_READY(rd_ready), .GRANT(grant), .RD_VALID(rd_valid),
    .RD_DATA(rd_data), .WORDS_LEFT(words_left), .TIMEOUT_ERR(timeout_err)
  );

  always #5 sclk = ~sclk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  localparam int PIdle = 0, PStart = 1, PWait = 2, PServe = 3;
  int          m_phase = PIdle;
  logic [31:0] m_words[$];
  int          m_wait = 0;
  int          m_last = NREQ - 1;
  int          m_gidx = -1;
  bit          m_terr = 1'b0;

  logic [31:0] dut_word[$];
  int          dut_req[$];
  int          dut_cyc[$];

  function automatic bit bitof(logic [NREQ-1:0] v, int i);
    logic [NREQ-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic int oh_idx(logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (bitof(v, i)) return i;
    return -1;
  endfunction

  task automatic model_step();
    cyc++;
    if (rst && rd_valid && (grant & rd_ready) != '0) begin
      dut_word.push_back(rd_data);
      dut_req.push_back(oh_idx(grant));
      dut_cyc.push_back(cyc);
    end
    if (!rst) begin
      chk_en  = 1'b1;
      m_phase = PIdle;
      m_words.delete();
      m_wait  = 0;
      m_last  = NREQ - 1;
      m_gidx  = -1;
      m_terr  = 1'b0;
    end else begin
      case (m_phase)
        PIdle: begin
          if (en && m_words.size() == 0) m_phase = PStart;
          else if (m_words.size() != 0) m_phase = PServe;
        end
        PStart: begin
          m_wait  = 0;
          m_phase = PWait;
        end
        PWait: begin
          m_wait++;
          if (gen_valid) begin
            m_words.delete();
            for (int k = 0; k < 16; k++) m_words.push_back(rn[511-32*k -: 32]);
            m_phase = PServe;
          end else if (m_wait == TO - 1) begin
            m_terr  = 1'b1;
            m_phase = PIdle;
          end
        end
        default: begin
          if (m_gidx >= 0) begin
            if (bitof(rd_ready, m_gidx)) begin
              void'(m_words.pop_front());
              m_last = m_gidx;
              m_gidx = -1;
              if (m_words.size() == 0) m_phase = PIdle;
            end else if (!bitof(req, m_gidx)) begin
              m_gidx = -1;
            end
          end else if (en && m_words.size() != 0) begin
            for (int j = 1; j <= NREQ; j++) begin
              int c;
              c = (m_last + j) % NREQ;
              if (bitof(req, c)) begin
                m_gidx = c;
                break;
              end
            end
          end
        end
      endcase
    end
  endtask

  always @(posedge sclk) model_step();

  always @(negedge sclk) begin
    logic [NREQ-1:0] eg;
    logic [31:0]     ed;
    if (chk_en) begin
      eg = (m_gidx >= 0) ? (NREQ'(1) << m_gidx) : '0;
      ed = (m_gidx >= 0) ? m_words[0] : 32'h0;
      vectors++;
      if (gen_start !== (m_phase == PStart) || grant !== eg || rd_valid !== (m_gidx >= 0) ||
          rd_data !== ed || words_left !== 5'(m_words.size()) || timeout_err !== m_terr) begin
        miscompares++;
        $display("FAIL model_cycle cyc=%0d got gs=%b g=%b v=%b d=%h wl=%0d te=%b want gs=%b g=%b v=%b d=%h wl=%0d te=%b",
                 cyc, gen_start, grant, rd_valid, rd_data, words_left, timeout_err,
                 m_phase == PStart, eg, m_gidx >= 0, ed, m_words.size(), m_terr);
      end
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge sclk);
    #1;
  endtask

  task automatic make_rn(logic [31:0] base);
    for (int k = 0; k < 16; k++) rn[511-32*k -: 32] = base + 32'(k);
  endtask

  task automatic wait_log(int target, int budget, string name);
    int n = 0;
    while (dut_word.size() < target && n < budget) begin
      tick(1);
      n++;
    end
    check(name, 32'(dut_word.size()), 32'(target));
  endtask

  task automatic check_all_zero(string name);
    check({name, "_gs"}, 32'(gen_start), 0);
    check({name, "_grant"}, 32'(grant), 0);
    check({name, "_valid"}, 32'(rd_valid), 0);
    check({name, "_data"}, rd_data, 0);
    check({name, "_wl"}, 32'(words_left), 0);
    check({name, "_terr"}, 32'(timeout_err), 0);
  endtask

  initial begin
    int n;
    rst = 1'b0; en = 1'b1; gen_valid = 1'b0; rn = '0; req = '0; rd_ready = '0;
    tick(2);
    check_all_zero("reset");

    // Startup: START one cycle after the first IDLE cycle, data 5 cycles after GEN_START.
    rst = 1'b1;
    tick(1);
    check("startup_gen_start", 32'(gen_start), 1);
    tick(1);
    check("startup_gen_start_drop", 32'(gen_start), 0);
    tick(4);
    gen_valid = 1'b1; make_rn(32'h0);
    tick(1);
    gen_valid = 1'b0;
    check("startup_words_left", 32'(words_left), 16);

    // Drain to requester 0: words 0..15 in order, one every 2 cycles, then refill.
    req = 4'b0001; rd_ready = 4'b0001;
    wait_log(16, 60, "drain0_count");
    req = '0;
    for (int i = 0; i < 16; i++) begin
      check("drain0_word", dut_word[i], 32'(i));
      check("drain0_req", 32'(dut_req[i]), 0);
      if (i > 0) check("drain0_spacing", 32'(dut_cyc[i] - dut_cyc[i-1]), 2);
    end
    check("drain0_empty", 32'(words_left), 0);
    tick(1);
    check("refill_gen_start", 32'(gen_start), 1);
    tick(3);
    gen_valid = 1'b1; make_rn(32'h100);
    tick(1);
    gen_valid = 1'b0;
    check("refill_words_left", 32'(words_left), 16);

    // Round robin: prime last=3, then all request -> 0,1,2,3,0,...
    req = 4'b1000; rd_ready = 4'b1111;
    wait_log(17, 10, "rr_prime_count");
    req = '0;
    check("rr_prime_req", 32'(dut_req[16]), 3);
    check("rr_prime_word", dut_word[16], 32'h100);
    req = 4'b1111;
    wait_log(25, 40, "rr_count");
    req = '0;
    for (int i = 0; i < 8; i++) begin
      check("rr_req", 32'(dut_req[17+i]), 32'(i % 4));
      check("rr_word", dut_word[17+i], 32'h101 + 32'(i));
    end
    check("rr_words_left", 32'(words_left), 7);

    // Withdrawn grant: requester 2 drops out, word 0x109 goes to requester 3 instead.
    req = 4'b0100; rd_ready = '0;
    n = 0;
    while (grant !== 4'b0100 && n < 10) begin tick(1); n++; end
    check("wd_grant2", 32'(grant), 32'h4);
    check("wd_data2", rd_data, 32'h109);
    req = 4'b1000;
    tick(1);
    check("wd_withdrawn", 32'(grant), 0);
    check("wd_words_left", 32'(words_left), 7);
    tick(1);
    check("wd_grant3", 32'(grant), 32'h8);
    check("wd_data3", rd_data, 32'h109);
    rd_ready = 4'b1000;
    tick(1);
    req = '0; rd_ready = '0;
    check("wd_log_word", dut_word[25], 32'h109);
    check("wd_log_req", 32'(dut_req[25]), 3);
    check("wd_words_after", 32'(words_left), 6);

    // EN low: no new grants.
    en = 1'b0; req = 4'b0001; rd_ready = 4'b0001;
    tick(4);
    check("en_low_grant", 32'(grant), 0);
    check("en_low_wl", 32'(words_left), 6);
    en = 1'b1;
    wait_log(32, 30, "drain1_count");
    req = '0; rd_ready = '0;
    check("drain1_empty", 32'(words_left), 0);

    // Timeout: no GEN_VALID, TIMEOUT_ERR rises exactly TO cycles after GEN_START.
    tick(1);
    check("to_gen_start", 32'(gen_start), 1);
    tick(TO - 1);
    check("to_not_yet", 32'(timeout_err), 0);
    tick(1);
    check("to_set", 32'(timeout_err), 1);
    tick(1);
    check("to_retry_gen_start", 32'(gen_start), 1);
    tick(2);
    gen_valid = 1'b1; make_rn(32'h200);
    tick(1);
    gen_valid = 1'b0;
    check("to_retry_wl", 32'(words_left), 16);
    check("to_sticky", 32'(timeout_err), 1);

    // Reset mid-SERVE at 9 words left; stray GEN_VALID in IDLE must be ignored.
    req = 4'b0001; rd_ready = 4'b0001;
    n = 0;
    while (words_left != 5'd9 && n < 40) begin tick(1); n++; end
    req = '0; rd_ready = '0;
    check("mid_wl9", 32'(words_left), 9);
    check("mid_first_word", dut_word[32], 32'h200);
    en = 1'b0; rst = 1'b0;
    tick(1);
    check_all_zero("mid_reset");
    rst = 1'b1;
    tick(1);
    gen_valid = 1'b1; make_rn(32'hdead0000);
    tick(1);
    gen_valid = 1'b0;
    tick(2);
    check("stray_wl", 32'(words_left), 0);
    check("stray_gs", 32'(gen_start), 0);
    check("stray_valid", 32'(rd_valid), 0);
    en = 1'b1;
    tick(1);
    check("post_reset_gen_start", 32'(gen_start), 1);
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end
endmodule

// File: doc/trng_word_arbiter.md
Name: trng_word_arbiter

Overview:
- Sits between the temperature-sensor TRNG core (512-bit RANDOM_NUMBER plus completion strobe) and up to NREQ consumers.
- Sequences generation runs and captures each 512-bit result into a 16x32 word buffer.
- Hands out words one at a time to requesters using round-robin arbitration.
- Each word is delivered exactly once and then scrubbed; an empty buffer triggers an automatic refill.

Parameters:
- NREQ, 4, number of requesters (2..8).
- GEN_TIMEOUT, 1024, max cycles to wait for GEN_VALID after GEN_START (>=2).

Ports:
- SCLK  input  1  system clock; all logic on posedge.
- RST  input  1  synchronous reset, active-low.
- EN  input  1  block enable; low blocks new generation runs and new grants.
- GEN_START  output  1  one-cycle pulse that starts a TRNG generation run.
- GEN_VALID  input  1  TRNG strobe; RANDOM_NUMBER is valid in this cycle.
- RANDOM_NUMBER  input  512  TRNG result.
- REQ  input  NREQ  level request per consumer.
- RD_READY  input  NREQ  per-consumer accept.
- GRANT  output  NREQ  one-hot grant, registered.
- RD_VALID  output  1  RD_DATA valid for the granted consumer.
- RD_DATA  output  32  random word; 0 when RD_VALID is low.
- WORDS_LEFT  output  5  unread words in the buffer (0..16).
- TIMEOUT_ERR  output  1  sticky; set on generation timeout, cleared only by reset.

Behaviour:
- Reset (RST=0 at posedge):
  - GEN_START=0, GRANT=0, RD_VALID=0, RD_DATA=0, WORDS_LEFT=0, TIMEOUT_ERR=0.
  - All buffer words zeroed; read pointer=0; round-robin last-grant=NREQ-1; timeout counter=0; state=IDLE.
  - Reset mid-run discards buffer contents and any pending generation. A GEN_VALID arriving after reset is ignored unless the block is in WAIT_GEN.
- FSM states: IDLE, START, WAIT_GEN, SERVE.
- IDLE:
  - If EN=1 and WORDS_LEFT=0, go to START.
  - If WORDS_LEFT>0, go to SERVE.
- START: GEN_START=1 for exactly this one cycle; timeout counter cleared; next state WAIT_GEN.
- WAIT_GEN:
  - Counter increments every cycle.
  - On GEN_VALID=1, capture word k = RANDOM_NUMBER[511-32k -: 32] for k=0..15, so word 0 = bits 511:480. Set WORDS_LEFT=16 and pointer=0; go to SERVE on the next cycle.
  - If GEN_VALID is also high on the expiry cycle, the capture wins.
  - If the counter reaches GEN_TIMEOUT without GEN_VALID, set TIMEOUT_ERR=1 and go to IDLE, which retries via START when EN=1.
  - GEN_VALID in any state other than WAIT_GEN is ignored.
- SERVE, arbitration (only when no grant is held, EN=1 and WORDS_LEFT>0):
  - Pick the first asserted REQ searching from (last+1) mod NREQ upward.
  - GRANT and RD_VALID assert on the next cycle, with RD_DATA = buffer[pointer].
- SERVE, handshake:
  - A word is consumed in a cycle where RD_VALID=1 and RD_READY[g]=1 for the granted index g. RD_READY bits of non-granted consumers are ignored.
  - On consume:
    - buffer[pointer] is zeroed.
    - pointer increments.
    - WORDS_LEFT decrements.
    - last is set to g.
    - GRANT, RD_VALID and RD_DATA drop to 0 next cycle.
  - This gives one word per 2 cycles maximum throughput, and one word per grant.
- SERVE, withdrawn request: if REQ[g] drops while granted and RD_READY[g]=0, the grant is withdrawn next cycle, the word is not consumed, and last is unchanged.
- SERVE, exit: when WORDS_LEFT reaches 0 after a consume, go to IDLE, which immediately refills if EN=1. Prefetch happens regardless of REQ.
- EN=0:
  - A held grant completes or withdraws normally.
  - No new grants are issued.
  - No START entry.
  - A generation run already in WAIT_GEN completes and is captured.
- WORDS_LEFT never wraps: 16 only after capture, 0 minimum. The pointer is 4 bits and is cleared on capture.
- GRANT is always one-hot or zero. RD_VALID equals the OR-reduction of GRANT.

Test Plan:
- Reset release with EN=1: GEN_START pulses 1 cycle after leaving IDLE. Drive GEN_VALID 5 cycles later with RANDOM_NUMBER = 0x00000000_00000001_…_0000000F → WORDS_LEFT=16.
- Refill trigger: REQ[0] held and RD_READY[0] tied high → 16 words 0x0..0xF delivered in order, one every 2 cycles. After the 16th, WORDS_LEFT=0, the FSM enters IDLE and a new GEN_START fires.
- Round-robin fairness: REQ=4'b1111, all RD_READY=1 → grant order 0,1,2,3,0,…; every word is served once with no duplicates.
- Withdrawn request: GRANT[2] issued, REQ[2] dropped before RD_READY → the same word is next served to requester 3, and WORDS_LEFT is unchanged by the withdrawal.
- Timeout: GEN_VALID never driven → TIMEOUT_ERR=1 exactly GEN_TIMEOUT cycles after GEN_START, then a new GEN_START. A later valid run still delivers data with TIMEOUT_ERR staying 1.
- Reset mid-SERVE: RST=0 at WORDS_LEFT=9 → next cycle all outputs are 0 and the buffer is cleared. A stray GEN_VALID pulse during IDLE is ignored and WORDS_LEFT stays 0.
